// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the multi-mode raster generator: the
// per-mode timing record, the built-in mode table and total-length helpers.
package vga_timing_pkg;

  localparam int TIMING_W  = 12;
  localparam int MAX_MODES = 4;

  // One raster mode: horizontal/vertical active, front porch, sync, back
  // porch lengths plus sync polarities (1 = active-high sync pulse).
  typedef struct packed {
    logic [TIMING_W-1:0] h_act;
    logic [TIMING_W-1:0] h_fp;
    logic [TIMING_W-1:0] h_sync;
    logic [TIMING_W-1:0] h_bp;
    logic [TIMING_W-1:0] v_act;
    logic [TIMING_W-1:0] v_fp;
    logic [TIMING_W-1:0] v_sync;
    logic [TIMING_W-1:0] v_bp;
    logic                hs_pol;
    logic                vs_pol;
  } vga_mode_t;

  typedef vga_mode_t [MAX_MODES-1:0] vga_mode_tbl_t;

  // Builds a mode record from plain integers so tables stay readable.
  function automatic vga_mode_t mk_mode(input int ha, input int hf, input int hsy, input int hb,
                                        input int va, input int vf, input int vsy, input int vb,
                                        input logic hp, input logic vp);
    vga_mode_t m;
    m.h_act  = TIMING_W'(ha);
    m.h_fp   = TIMING_W'(hf);
    m.h_sync = TIMING_W'(hsy);
    m.h_bp   = TIMING_W'(hb);
    m.v_act  = TIMING_W'(va);
    m.v_fp   = TIMING_W'(vf);
    m.v_sync = TIMING_W'(vsy);
    m.v_bp   = TIMING_W'(vb);
    m.hs_pol = hp;
    m.vs_pol = vp;
    return m;
  endfunction

  // Index 0: 640x480, 1: 800x600, 2: 1280x720, 3: 1920x1080.
  localparam vga_mode_tbl_t MODE_TABLE = {
    mk_mode(1920,  88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1),
    mk_mode(1280, 110, 40, 220,  720, 5, 5, 20, 1'b1, 1'b1),
    mk_mode( 800,  40, 128, 88,  600, 1, 4, 23, 1'b1, 1'b1),
    mk_mode( 640,  16, 96,  48,  480, 10, 2, 33, 1'b0, 1'b0)
  };

  function automatic logic [TIMING_W-1:0] h_total(input vga_mode_t m);
    return m.h_act + m.h_fp + m.h_sync + m.h_bp;
  endfunction

  function automatic logic [TIMING_W-1:0] v_total(input vga_mode_t m);
    return m.v_act + m.v_fp + m.v_sync + m.v_bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter ordered sync, back porch,
// active, front porch, with combinational decode of the current position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int COORD_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COORD_W-1:0] act,
  input  logic [COORD_W-1:0] fp,
  input  logic [COORD_W-1:0] sync,
  input  logic [COORD_W-1:0] bp,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap,
  output logic               sync_on,
  output logic               active,
  output logic [COORD_W-1:0] offset
);

  logic [COORD_W-1:0] cnt_q;
  logic [COORD_W-1:0] total;
  logic [COORD_W-1:0] act_lo;
  logic [COORD_W-1:0] act_hi;

  assign total   = act + fp + sync + bp;
  assign act_lo  = sync + bp;
  assign act_hi  = act_lo + act;

  assign cnt     = cnt_q;
  assign wrap    = (cnt_q == total - COORD_W'(1));
  assign sync_on = (cnt_q < sync);
  assign active  = (cnt_q >= act_lo) && (cnt_q < act_hi);
  assign offset  = cnt_q - act_lo;

  // Advance one position per enable; the end of the axis is found by compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : cnt_q + COORD_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Multi-mode raster timing generator. Two axis counters walk the frame; the
// mode register only follows mode_sel at the frame wrap so a frame is never
// torn; one registered stage aligns syncs, de, coordinates, mode and strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int            NUM_MODES    = 4,
  parameter int            DEFAULT_MODE = 0,
  parameter int            COORD_W      = 12,
  parameter vga_mode_tbl_t MODES        = MODE_TABLE,
  localparam int           MSEL_W       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [MSEL_W-1:0]  mode_sel,
  output logic [MSEL_W-1:0]  mode_cur,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam vga_mode_t DEF_TIMING = MODES[DEFAULT_MODE];

  logic [MSEL_W-1:0]  mode_q;
  vga_mode_t          cur;
  logic               vld_p0;

  logic [COORD_W-1:0] h_cnt, v_cnt, h_off, v_off;
  logic               h_wrap, v_wrap, h_sync_on, v_sync_on, h_act_on, v_act_on;
  logic               frame_wrap;
  logic               de_p0;

  logic [MSEL_W-1:0]  mode_cur_p1;
  logic               hs_p1, vs_p1, de_p1, line_start_p1, frame_start_p1;
  logic [COORD_W-1:0] x_p1, y_p1;

  assign cur        = MODES[mode_q];
  assign vld_p0     = ce;
  assign frame_wrap = vld_p0 && h_wrap && v_wrap;

  vga_axis_counter #(.COORD_W(COORD_W)) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (vld_p0),
    .act     (COORD_W'(cur.h_act)),
    .fp      (COORD_W'(cur.h_fp)),
    .sync    (COORD_W'(cur.h_sync)),
    .bp      (COORD_W'(cur.h_bp)),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .sync_on (h_sync_on),
    .active  (h_act_on),
    .offset  (h_off)
  );

  vga_axis_counter #(.COORD_W(COORD_W)) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (vld_p0 && h_wrap),
    .act     (COORD_W'(cur.v_act)),
    .fp      (COORD_W'(cur.v_fp)),
    .sync    (COORD_W'(cur.v_sync)),
    .bp      (COORD_W'(cur.v_bp)),
    .cnt     (v_cnt),
    .wrap    (v_wrap),
    .sync_on (v_sync_on),
    .active  (v_act_on),
    .offset  (v_off)
  );

  assign de_p0 = h_act_on && v_act_on;

  // Accept a new mode only at the frame wrap, ignoring out-of-range requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MSEL_W'(DEFAULT_MODE);
    end else if (frame_wrap && (int'(mode_sel) < NUM_MODES)) begin
      mode_q <= mode_sel;
    end
  end

  // Output stage: decode of the pre-edge counters, held while ce is low;
  // strobes are re-evaluated every clk so they last exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_cur_p1    <= MSEL_W'(DEFAULT_MODE);
      hs_p1          <= ~DEF_TIMING.hs_pol;
      vs_p1          <= ~DEF_TIMING.vs_pol;
      de_p1          <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      line_start_p1  <= vld_p0 && (h_cnt == '0);
      frame_start_p1 <= vld_p0 && (h_cnt == '0) && (v_cnt == '0);
      if (vld_p0) begin
        mode_cur_p1 <= mode_q;
        hs_p1       <= h_sync_on ? cur.hs_pol : ~cur.hs_pol;
        vs_p1       <= v_sync_on ? cur.vs_pol : ~cur.vs_pol;
        de_p1       <= de_p0;
        x_p1        <= de_p0 ? h_off : '0;
        y_p1        <= de_p0 ? v_off : '0;
      end
    end
  end

  assign mode_cur    = mode_cur_p1;
  assign hs          = hs_p1;
  assign vs          = vs_p1;
  assign de          = de_p1;
  assign x           = x_p1;
  assign y           = y_p1;
  assign line_start  = line_start_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances on the real mode table (default
// modes 0, 1 and 3) plus one on a miniature table so frame wraps, mode
// switches, ce gating and mid-frame reset fit in a short run. A behavioural
// raster model feeds a scoreboard each cycle; directed checks cover the
// line-level timing of the real modes.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int NI = 4;

  typedef struct packed {
    logic [1:0]  mode;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        ls;
    logic        fs;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } tim_t;

  localparam vga_mode_tbl_t SMALL_TABLE = {
    mk_mode( 4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1),
    mk_mode(10, 2, 2, 2, 5, 1, 2, 2, 1'b1, 1'b0),
    mk_mode( 6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1),
    mk_mode( 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0)
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b, rst_s, ce_b, ce_s;
  logic [1:0] sel_b, sel_s;

  logic [1:0]  mc   [NI];
  logic        hs_o [NI];
  logic        vs_o [NI];
  logic        de_o [NI];
  logic [11:0] x_o  [NI];
  logic [11:0] y_o  [NI];
  logic        ls_o [NI];
  logic        fs_o [NI];

  vga_timing_gen #(.NUM_MODES(4), .DEFAULT_MODE(0), .COORD_W(12)) u_a (
    .clk(clk), .rst(rst_b), .ce(ce_b), .mode_sel(sel_b), .mode_cur(mc[0]),
    .hs(hs_o[0]), .vs(vs_o[0]), .de(de_o[0]), .x(x_o[0]), .y(y_o[0]),
    .line_start(ls_o[0]), .frame_start(fs_o[0]));

  vga_timing_gen #(.NUM_MODES(4), .DEFAULT_MODE(1), .COORD_W(12)) u_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .mode_sel(sel_b), .mode_cur(mc[1]),
    .hs(hs_o[1]), .vs(vs_o[1]), .de(de_o[1]), .x(x_o[1]), .y(y_o[1]),
    .line_start(ls_o[1]), .frame_start(fs_o[1]));

  vga_timing_gen #(.NUM_MODES(4), .DEFAULT_MODE(3), .COORD_W(12)) u_c (
    .clk(clk), .rst(rst_b), .ce(ce_b), .mode_sel(sel_b), .mode_cur(mc[2]),
    .hs(hs_o[2]), .vs(vs_o[2]), .de(de_o[2]), .x(x_o[2]), .y(y_o[2]),
    .line_start(ls_o[2]), .frame_start(fs_o[2]));

  vga_timing_gen #(.NUM_MODES(3), .DEFAULT_MODE(0), .COORD_W(12), .MODES(SMALL_TABLE)) u_s (
    .clk(clk), .rst(rst_s), .ce(ce_s), .mode_sel(sel_s), .mode_cur(mc[3]),
    .hs(hs_o[3]), .vs(vs_o[3]), .de(de_o[3]), .x(x_o[3]), .y(y_o[3]),
    .line_start(ls_o[3]), .frame_start(fs_o[3]));

  tim_t tab    [NI][4];
  int   nmodes [NI];
  int   defm   [NI];
  int   mh [NI], mv [NI], mm [NI];
  obs_t mo [NI];
  obs_t sbq [$];

  int checks = 0;
  int errors = 0;

  int nb = 0;
  int hs_lo_a = 0, hs_hi_b = 0, hs_hi_c = 0;
  int de_a = 0, x_first_a = -1, x_last_a = -1, ls_a = 0;
  int vs_hi_b = 0, de_b = 0, x_last_b = -1, y_max_b = 0;

  task automatic set_tab(input int k, input int m, input int ha, input int hf, input int hsy,
                         input int hb, input int va, input int vf, input int vsy, input int vb,
                         input bit hp, input bit vp);
    tab[k][m].ha = ha; tab[k][m].hf = hf; tab[k][m].hs = hsy; tab[k][m].hb = hb;
    tab[k][m].va = va; tab[k][m].vf = vf; tab[k][m].vs = vsy; tab[k][m].vb = vb;
    tab[k][m].hp = hp; tab[k][m].vp = vp;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic obs_t actual(input int k);
    obs_t r;
    r.mode = mc[k];   r.hs = hs_o[k]; r.vs = vs_o[k]; r.de = de_o[k];
    r.x    = x_o[k];  r.y  = y_o[k];  r.ls = ls_o[k]; r.fs = fs_o[k];
    return r;
  endfunction

  task automatic model_reset(input int k);
    mh[k] = 0; mv[k] = 0; mm[k] = defm[k];
    mo[k].mode = 2'(defm[k]);
    mo[k].hs   = !tab[k][defm[k]].hp;
    mo[k].vs   = !tab[k][defm[k]].vp;
    mo[k].de   = 1'b0;
    mo[k].x    = 12'd0;
    mo[k].y    = 12'd0;
    mo[k].ls   = 1'b0;
    mo[k].fs   = 1'b0;
  endtask

  // Expected outputs after the next clk edge, then the counter advance.
  task automatic model_step(input int k, input bit cek, input bit rstk, input int sel);
    tim_t t;
    int   htot, vtot, ah, av;
    bit   d;
    if (!rstk) begin
      model_reset(k);
      return;
    end
    t = tab[k][mm[k]];
    if (cek) begin
      htot = t.ha + t.hf + t.hs + t.hb;
      vtot = t.va + t.vf + t.vs + t.vb;
      ah   = t.hs + t.hb;
      av   = t.vs + t.vb;
      d    = (mh[k] >= ah) && (mh[k] < ah + t.ha) && (mv[k] >= av) && (mv[k] < av + t.va);
      mo[k].mode = 2'(mm[k]);
      mo[k].hs   = (mh[k] < t.hs) ? t.hp : !t.hp;
      mo[k].vs   = (mv[k] < t.vs) ? t.vp : !t.vp;
      mo[k].de   = d;
      mo[k].x    = d ? 12'(mh[k] - ah) : 12'd0;
      mo[k].y    = d ? 12'(mv[k] - av) : 12'd0;
      mo[k].ls   = (mh[k] == 0);
      mo[k].fs   = (mh[k] == 0) && (mv[k] == 0);
      if (mh[k] == htot - 1) begin
        mh[k] = 0;
        if (mv[k] == vtot - 1) begin
          mv[k] = 0;
          if (sel < nmodes[k]) mm[k] = sel;
        end else begin
          mv[k] = mv[k] + 1;
        end
      end else begin
        mh[k] = mh[k] + 1;
      end
    end else begin
      mo[k].ls = 1'b0;
      mo[k].fs = 1'b0;
    end
  endtask

  // One clk: push predictions, take the edge, pop and compare every instance.
  task automatic step();
    obs_t e, a;
    for (int k = 0; k < NI; k++) begin
      if (k < 3) model_step(k, ce_b, rst_b, int'(sel_b));
      else       model_step(k, ce_s, rst_s, int'(sel_s));
      sbq.push_back(mo[k]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      e = sbq.pop_front();
      a = actual(k);
      checks++;
      assert (a === e) else begin
        errors++;
        $error("FAIL out%0d got=%h want=%h", k, a, e);
      end
    end
    if (rst_b) begin
      nb++;
      if (nb <= 800) begin
        if (hs_o[0] === 1'b0) hs_lo_a++;
        if (hs_o[1] === 1'b1) hs_hi_b++;
        if (hs_o[2] === 1'b1) hs_hi_c++;
      end
      if (nb <= 28800) begin
        if (de_o[0] === 1'b1) begin
          if (de_a == 0) x_first_a = int'(x_o[0]);
          x_last_a = int'(x_o[0]);
          de_a++;
        end
        if (ls_o[0] === 1'b1) ls_a++;
      end
      if (vs_o[1] === 1'b1) vs_hi_b++;
      if (de_o[1] === 1'b1) begin
        de_b++;
        x_last_b = int'(x_o[1]);
        if (int'(y_o[1]) > y_max_b) y_max_b = int'(y_o[1]);
      end
    end
  endtask

  // Clocks between two frame_start strobes of the small instance.
  task automatic measure_fs(input bit toggle, output int period);
    bit found;
    found  = 1'b0;
    period = -1;
    for (int i = 0; i < 1000; i++) begin
      if (toggle) ce_s = ~ce_s;
      step();
      if (fs_o[3] === 1'b1) begin found = 1'b1; break; end
    end
    if (found) begin
      for (int i = 1; i < 1000; i++) begin
        if (toggle) ce_s = ~ce_s;
        step();
        if (fs_o[3] === 1'b1) begin period = i; break; end
      end
    end
  endtask

  initial begin
    int p;
    vga_mode_tbl_t tbl;

    for (int k = 0; k < 3; k++) begin
      set_tab(k, 0,  640,  16,  96,  48,  480, 10, 2, 33, 1'b0, 1'b0);
      set_tab(k, 1,  800,  40, 128,  88,  600,  1, 4, 23, 1'b1, 1'b1);
      set_tab(k, 2, 1280, 110,  40, 220,  720,  5, 5, 20, 1'b1, 1'b1);
      set_tab(k, 3, 1920,  88,  44, 148, 1080,  4, 5, 36, 1'b1, 1'b1);
      nmodes[k] = 4;
    end
    defm[0] = 0; defm[1] = 1; defm[2] = 3; defm[3] = 0;
    set_tab(3, 0,  8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0);
    set_tab(3, 1,  6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    set_tab(3, 2, 10, 2, 2, 2, 5, 1, 2, 2, 1'b1, 1'b0);
    set_tab(3, 3,  4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    nmodes[3] = 3;

    rst_b = 1'b1; rst_s = 1'b1;
    ce_b = 1'b0; ce_s = 1'b0; sel_b = 2'd0; sel_s = 2'd0;
    #1;
    rst_b = 1'b0; rst_s = 1'b0;
    for (int k = 0; k < NI; k++) model_reset(k);
    #2;
    for (int k = 0; k < NI; k++) chk($sformatf("reset_out%0d", k), 32'(actual(k)), 32'(mo[k]));

    // ce high while reset is held: everything stays at reset values.
    ce_b = 1'b1; ce_s = 1'b1;
    step();
    step();

    rst_b = 1'b1; rst_s = 1'b1;
    step();
    chk("first_ce_frame_start", 32'(fs_o[0]), 32'd1);
    chk("first_ce_line_start",  32'(ls_o[0]), 32'd1);
    chk("first_ce_hs_active",   32'(hs_o[0]), 32'd0);
    chk("first_ce_vs_b_active", 32'(vs_o[1]), 32'd1);

    // Small instance: mid-frame mode request waits for the wrap.
    repeat (129) step();
    sel_s = 2'd2;
    repeat (30) step();
    chk("mode_hold_midframe", 32'(mc[3]), 32'd0);
    for (int i = 0; i < 200; i++) begin
      step();
      if (mc[3] !== 2'd0) break;
    end
    chk("mode_switch_value", 32'(mc[3]), 32'd2);
    chk("mode_switch_with_fs", 32'(fs_o[3]), 32'd1);

    // Out-of-range request across a wrap leaves the mode and timing alone.
    sel_s = 2'd3;
    measure_fs(1'b0, p);
    chk("mode2_frame_period", 32'(p), 32'd160);
    chk("mode_ignore_oor", 32'(mc[3]), 32'd2);

    // ce toggling halves the frame rate.
    measure_fs(1'b1, p);
    chk("ce_toggle_period", 32'(p), 32'd320);
    ce_s = 1'b1;

    // Reset mid-frame in mode 2, between clk edges.
    for (int i = 0; i < 400; i++) begin
      if (mh[3] == 9 && mv[3] == 6 && mm[3] == 2) break;
      step();
    end
    chk("reached_midframe", 32'(mh[3] == 9 && mv[3] == 6), 32'd1);
    #3;
    rst_s = 1'b0;
    #1;
    model_reset(3);
    chk("async_reset_out", 32'(actual(3)), 32'(mo[3]));
    chk("async_reset_mode", 32'(mc[3]), 32'd0);
    step();
    rst_s = 1'b1;
    step();
    chk("post_reset_fs", 32'(fs_o[3]), 32'd1);
    chk("post_reset_mode", 32'(mc[3]), 32'd0);
    measure_fs(1'b0, p);
    chk("post_reset_period", 32'(p), 32'd120);

    // Let the real-table instances reach their first active lines.
    while (nb < 29600) step();

    chk("a_hs_low_clks",   32'(hs_lo_a), 32'd96);
    chk("a_de_count",      32'(de_a), 32'd640);
    chk("a_x_first",       32'(x_first_a), 32'd0);
    chk("a_x_last",        32'(x_last_a), 32'd639);
    chk("a_line_starts",   32'(ls_a), 32'd36);
    chk("b_hs_high_clks",  32'(hs_hi_b), 32'd128);
    chk("b_vs_high_clks",  32'(vs_hi_b), 32'd4224);
    chk("b_de_count",      32'(de_b), 32'd800);
    chk("b_x_last",        32'(x_last_b), 32'd799);
    chk("b_y_max",         32'(y_max_b), 32'd0);
    chk("c_hs_high_clks",  32'(hs_hi_c), 32'd44);

    tbl = MODE_TABLE;
    chk("pkg_h_total_m0", 32'(h_total(tbl[0])), 32'd800);
    chk("pkg_v_total_m0", 32'(v_total(tbl[0])), 32'd525);
    chk("pkg_h_total_m2", 32'(h_total(tbl[2])), 32'd1650);
    chk("pkg_v_total_m3", 32'(v_total(tbl[3])), 32'd1125);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
